// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM request arbiter: address-width derivation,
// the port identifier stored per outstanding read, and the arbiter FSM encoding.
package sdram_pkg;

  localparam int ROW_BITS_DEF  = 13;
  localparam int COL_BITS_DEF  = 9;
  localparam int BANK_BITS_DEF = 2;

  function automatic int addr_w(input int row_bits, input int col_bits, input int bank_bits);
    return row_bits + col_bits + bank_bits;
  endfunction

  typedef logic port_id_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sdram_tag_fifo.sv
// In-order tag FIFO with an extra wrap bit on each pointer for full/empty;
// a push and a pop in the same cycle are both honoured, including when full.
module sdram_tag_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_req_arb.sv
// Two-port request arbiter in front of the SDRAM controller command port, with
// read-response steering by tag FIFO. Define SDRAM_ARB_FIXED_PRIO_EN for port-0 priority.
module sdram_req_arb
  import sdram_pkg::*;
#(
  parameter  int ROW_BITS  = ROW_BITS_DEF,
  parameter  int COL_BITS  = COL_BITS_DEF,
  parameter  int BANK_BITS = BANK_BITS_DEF,
  parameter  int TAG_DEPTH = 4,
  localparam int ADDR_W    = addr_w(ROW_BITS, COL_BITS, BANK_BITS),
  localparam int CNT_W     = $clog2(TAG_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [15:0]       p0_wdata,
  output logic              p0_rvalid,
  output logic [15:0]       p0_rdata,
  input  logic              p0_rready,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [15:0]       p1_wdata,
  output logic              p1_rvalid,
  output logic [15:0]       p1_rdata,
  input  logic              p1_rready,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [15:0]       cmd_wdata,
  input  logic              rsp_valid,
  input  logic [15:0]       rsp_rdata,
  output logic              rsp_ready,
  output logic              tag_err,
  output logic [CNT_W-1:0]  outstanding
);

  arb_state_e        state_q, state_d;
  logic              cmd_valid_q, cmd_write_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [15:0]       cmd_wdata_q;
  logic              tag_err_q;
  logic              elig0, elig1;
  logic              gnt0, gnt1, gnt;
  logic              sel_write;
  logic              fifo_full, fifo_empty, fifo_pop;
  port_id_t          head_id;

  assign elig0     = p0_valid & (p0_write | ~fifo_full);
  assign elig1     = p1_valid & (p1_write | ~fifo_full);
  assign gnt       = gnt0 | gnt1;
  assign sel_write = gnt1 ? p1_write : p0_write;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt) state_d = S_ISSUE;
      S_ISSUE: if (cmd_valid_q && cmd_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_IDLE && !rst) begin
      gnt0 = elig0;
      gnt1 = elig1 & ~elig0;
    end
  end
`else
  // prio_q names the port that wins the next tie; the loser of a grant gets it.
  port_id_t prio_q;

  always_ff @(posedge clk) begin
    if (rst)       prio_q <= 1'b0;
    else if (gnt)  prio_q <= ~port_id_t'(gnt1);
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_IDLE && !rst) begin
      if (elig0 && elig1) begin
        gnt0 = (prio_q == 1'b0);
        gnt1 = (prio_q == 1'b1);
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end
  end
`endif

  assign p0_ready = gnt0;
  assign p1_ready = gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else if (gnt) begin
      cmd_valid_q <= 1'b1;
      cmd_write_q <= sel_write;
      cmd_addr_q  <= gnt1 ? p1_addr  : p0_addr;
      cmd_wdata_q <= gnt1 ? p1_wdata : p0_wdata;
    end else if (cmd_valid_q && cmd_ready) begin
      cmd_valid_q <= 1'b0;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_write = cmd_write_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;

  sdram_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (gnt & ~sel_write),
    .din_i   (port_id_t'(gnt1)),
    .pop_i   (fifo_pop),
    .dout_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding)
  );

  // With no tag to steer by, stray responses are accepted and discarded.
  always_comb begin
    p0_rvalid = 1'b0;
    p1_rvalid = 1'b0;
    p0_rdata  = '0;
    p1_rdata  = '0;
    rsp_ready = 1'b0;
    if (fifo_empty) begin
      rsp_ready = rsp_valid;
    end else if (head_id == 1'b0) begin
      p0_rvalid = rsp_valid;
      p0_rdata  = rsp_rdata;
      rsp_ready = p0_rready;
    end else begin
      p1_rvalid = rsp_valid;
      p1_rdata  = rsp_rdata;
      rsp_ready = p1_rready;
    end
  end

  assign fifo_pop = rsp_valid & rsp_ready & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst)                          tag_err_q <= 1'b0;
    else if (rsp_valid && fifo_empty) tag_err_q <= 1'b1;
  end

  assign tag_err = tag_err_q;

endmodule

// File: tb/tb_sdram_req_arb.sv
// Directed bench for sdram_req_arb: issue latency, arbitration order, response
// steering, tag-FIFO full blocking, command stall stability and stray-response flagging.
module tb_sdram_req_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p0_ready, p0_write, p0_rvalid, p0_rready;
  logic        p1_valid, p1_ready, p1_write, p1_rvalid, p1_rready;
  logic [23:0] p0_addr, p1_addr, cmd_addr;
  logic [15:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, cmd_wdata, rsp_rdata;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic        rsp_valid, rsp_ready, tag_err;
  logic [2:0]  outstanding;

  int total = 0;
  int bad   = 0;
  bit exp_tags[$];
  bit exp_g [4];

  always #5 clk = ~clk;

  sdram_req_arb dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_write(p0_write), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_rready(p0_rready),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_write(p1_write), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_rready(p1_rready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ready(rsp_ready),
    .tag_err(tag_err), .outstanding(outstanding)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input string tag, input logic [15:0] d);
    bit h;
    h = exp_tags.pop_front();
    rsp_valid = 1'b1;
    rsp_rdata = d;
    #1;
    chk({tag, "_rv0"}, 32'(p0_rvalid), 32'(h == 1'b0));
    chk({tag, "_rv1"}, 32'(p1_rvalid), 32'(h == 1'b1));
    chk({tag, "_rd0"}, 32'(p0_rdata), (h == 1'b0) ? 32'(d) : 32'h0);
    chk({tag, "_rd1"}, 32'(p1_rdata), (h == 1'b1) ? 32'(d) : 32'h0);
    chk({tag, "_rsp_ready"}, 32'(rsp_ready), 32'h1);
    step();
    rsp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    rst = 1'b1;
    p0_valid = 0; p0_write = 0; p0_addr = '0; p0_wdata = '0; p0_rready = 0;
    p1_valid = 0; p1_write = 0; p1_addr = '0; p1_wdata = '0; p1_rready = 0;
    cmd_ready = 0; rsp_valid = 0; rsp_rdata = '0;
    step(); step(); step();
    chk("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    chk("rst_cmd_addr", 32'(cmd_addr), 32'h0);
    chk("rst_outstanding", 32'(outstanding), 32'h0);
    chk("rst_tag_err", 32'(tag_err), 32'h0);
    chk("rst_rsp_ready", 32'(rsp_ready), 32'h0);
    rst = 1'b0;
    step();

    // single read: handshake cycle N, command visible cycle N+1
    p0_valid = 1; p0_write = 0; p0_addr = 24'h000123; cmd_ready = 1;
    #1;
    chk("t1_p0_ready", 32'(p0_ready), 32'h1);
    chk("t1_p1_ready", 32'(p1_ready), 32'h0);
    step();
    p0_valid = 0;
    #1;
    chk("t1_cmd_valid", 32'(cmd_valid), 32'h1);
    chk("t1_cmd_write", 32'(cmd_write), 32'h0);
    chk("t1_cmd_addr", 32'(cmd_addr), 32'h000123);
    chk("t1_outstanding", 32'(outstanding), 32'h1);
    step();
    chk("t1_cmd_done", 32'(cmd_valid), 32'h0);
    p0_rready = 1;
    exp_tags.push_back(1'b0);
    resp("t1_rsp", 16'h1111);
    #1;
    chk("t1_outst_zero", 32'(outstanding), 32'h0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // both ports hold reads: four grants
    p0_valid = 1; p0_write = 0; p0_addr = 24'h000A00;
    p1_valid = 1; p1_write = 0; p1_addr = 24'h000B01;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("t2_gnt_p0", 32'(p0_ready), 32'(exp_g[g] == 1'b0));
      chk("t2_gnt_p1", 32'(p1_ready), 32'(exp_g[g] == 1'b1));
      exp_tags.push_back(exp_g[g]);
      step();
      chk("t2_cmd_addr", 32'(cmd_addr), exp_g[g] ? 32'h000B01 : 32'h000A00);
      chk("t2_issue_nordy", 32'({p0_ready, p1_ready}), 32'h0);
      step();
    end
    chk("t4_outst_full", 32'(outstanding), 32'h4);
    chk("t4_reads_blocked", 32'({p0_ready, p1_ready}), 32'h0);

    // full tag FIFO: a write still goes through, then the controller stalls
    p1_write = 1; p1_wdata = 16'h5A5A; p1_addr = 24'h00C0DE; cmd_ready = 0;
    #1;
    chk("t4_wr_ready", 32'(p1_ready), 32'h1);
    chk("t4_rd_blocked", 32'(p0_ready), 32'h0);
    step();
    p1_addr = 24'hFFFFFF; p1_wdata = 16'h0000;
    #1;
    chk("t4_cmd_valid", 32'(cmd_valid), 32'h1);
    chk("t4_cmd_write", 32'(cmd_write), 32'h1);
    chk("t4_cmd_wdata", 32'(cmd_wdata), 32'h5A5A);
    chk("t4_cmd_addr", 32'(cmd_addr), 32'h00C0DE);
    chk("t4_outst", 32'(outstanding), 32'h4);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_cmd_valid", 32'(cmd_valid), 32'h1);
      chk("t5_cmd_addr", 32'(cmd_addr), 32'h00C0DE);
      chk("t5_cmd_wdata", 32'(cmd_wdata), 32'h5A5A);
      chk("t5_cmd_write", 32'(cmd_write), 32'h1);
      chk("t5_nordy", 32'({p0_ready, p1_ready}), 32'h0);
    end
    p0_valid = 0; p1_valid = 0; p1_write = 0; cmd_ready = 1;
    step();
    chk("t5_released", 32'(cmd_valid), 32'h0);

    // head port not ready: response held, nothing popped
    p0_rready = 0; p1_rready = 0;
    rsp_valid = 1; rsp_rdata = 16'hBEEF;
    #1;
    chk("t3_bp_rsp_ready", 32'(rsp_ready), 32'h0);
    step();
    rsp_valid = 0;
    chk("t3_bp_outst", 32'(outstanding), 32'h4);
    p0_rready = 1; p1_rready = 1;
    resp("t3_rsp0", 16'hBEEF);
    resp("t3_rsp1", 16'h1234);
    chk("t3_outst_two", 32'(outstanding), 32'h2);

    // push and pop in the same cycle
    rsp_valid = 1; rsp_rdata = 16'h7777;
    p1_valid = 1; p1_write = 0; p1_addr = 24'h000777;
    #1;
    chk("pp_p1_ready", 32'(p1_ready), 32'h1);
    chk("pp_rsp_ready", 32'(rsp_ready), 32'h1);
    step();
    void'(exp_tags.pop_front());
    exp_tags.push_back(1'b1);
    p1_valid = 0; rsp_valid = 0;
    #1;
    chk("pp_outst", 32'(outstanding), 32'h2);
    chk("pp_cmd_addr", 32'(cmd_addr), 32'h000777);
    step();
    resp("pp_rsp2", 16'h2222);
    resp("pp_rsp3", 16'h3333);
    chk("pp_outst_zero", 32'(outstanding), 32'h0);

    // stray response with nothing outstanding
    rsp_valid = 1; rsp_rdata = 16'hDEAD;
    #1;
    chk("t6_rsp_ready", 32'(rsp_ready), 32'h1);
    chk("t6_no_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'h0);
    chk("t6_err_before", 32'(tag_err), 32'h0);
    step();
    rsp_valid = 0;
    chk("t6_tag_err", 32'(tag_err), 32'h1);
    chk("t6_outst", 32'(outstanding), 32'h0);
    step(); step();
    chk("t6_sticky", 32'(tag_err), 32'h1);
    rst = 1;
    step();
    rst = 0;
    chk("t6_cleared", 32'(tag_err), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
